// File: rtl/cdc_fifo_wptr_full.sv
// Write-domain pointer logic for a dual-clock FIFO: owns the binary and Gray write pointers.
// It also synchronizes the read pointer into this domain and derives full, almost-full, fill count and sticky overflow.
module cdc_fifo_wptr_full #(
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_inc,
  input  logic [ADDR_SIZE:0]   r_ptr,
  input  logic                 w_overflow_clr,
  output logic [ADDR_SIZE:0]   w_ptr,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic                 w_mem_en,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [ADDR_SIZE:0]   w_count,
  output logic                 w_overflow
);

  localparam int A = ADDR_SIZE;
  localparam logic [A:0] AF_LEVEL = (A+1)'((1 << A) - ALMOST_FULL_MARGIN);

  logic [A:0] w_bin_q, w_bin_d;
  logic [A:0] w_ptr_q, w_ptr_d;
  logic [A:0] w_q1_rptr_q, w_q1_rptr_d;
  logic [A:0] w_q2_rptr_q, w_q2_rptr_d;
  logic [A:0] w_count_q, w_count_d;
  logic       w_full_q, w_full_d;
  logic       w_almost_full_q, w_almost_full_d;
  logic       w_overflow_q, w_overflow_d;
  logic [A:0] q2_rbin;
  logic [A:0] fill_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= A; gi++) begin : g_gray2bin
      assign q2_rbin[gi] = ^(w_q2_rptr_q >> gi);
    end
  endgenerate

  assign w_mem_en = w_inc & ~w_full_q;

  always_comb begin
    w_q1_rptr_d = r_ptr;
    w_q2_rptr_d = w_q1_rptr_q;
    w_bin_d     = w_bin_q + {{A{1'b0}}, w_mem_en};
    w_ptr_d     = (w_bin_d >> 1) ^ w_bin_d;
    fill_next   = w_bin_d - q2_rbin;
    // Flags use the next write pointer so an accepted write shows up with zero lag.
    w_full_d        = (w_ptr_d == {~w_q2_rptr_q[A:A-1], w_q2_rptr_q[A-2:0]});
    w_count_d       = fill_next;
    w_almost_full_d = (fill_next >= AF_LEVEL);
    w_overflow_d    = w_overflow_q;
    if (w_inc && w_full_q) begin
      w_overflow_d = 1'b1;
    end else if (w_overflow_clr) begin
      w_overflow_d = 1'b0;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_bin_q         <= '0;
      w_ptr_q         <= '0;
      w_q1_rptr_q     <= '0;
      w_q2_rptr_q     <= '0;
      w_count_q       <= '0;
      w_full_q        <= 1'b0;
      w_almost_full_q <= 1'b0;
      w_overflow_q    <= 1'b0;
    end else begin
      w_bin_q         <= w_bin_d;
      w_ptr_q         <= w_ptr_d;
      w_q1_rptr_q     <= w_q1_rptr_d;
      w_q2_rptr_q     <= w_q2_rptr_d;
      w_count_q       <= w_count_d;
      w_full_q        <= w_full_d;
      w_almost_full_q <= w_almost_full_d;
      w_overflow_q    <= w_overflow_d;
    end
  end

  assign w_ptr         = w_ptr_q;
  assign w_addr        = w_bin_q[A-1:0];
  assign w_full        = w_full_q;
  assign w_almost_full = w_almost_full_q;
  assign w_count       = w_count_q;
  assign w_overflow    = w_overflow_q;

endmodule

// File: tb/tb_cdc_fifo_wptr_full.sv
// Scoreboard bench for cdc_fifo_wptr_full: a counting model of writes/reads predicts every cycle's outputs.
// A separate monitor pops the predictions and compares them with the DUT.
module tb_cdc_fifo_wptr_full;

  localparam int AS     = 4;
  localparam int MARGIN = 2;
  localparam int DEPTH  = 1 << AS;

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b0;
  logic          w_inc = 1'b0;
  logic [AS:0]   r_ptr = '0;
  logic          w_overflow_clr = 1'b0;
  logic [AS:0]   w_ptr;
  logic [AS-1:0] w_addr;
  logic          w_mem_en;
  logic          w_full;
  logic          w_almost_full;
  logic [AS:0]   w_count;
  logic          w_overflow;

  cdc_fifo_wptr_full #(.ADDR_SIZE(AS), .ALMOST_FULL_MARGIN(MARGIN)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .r_ptr(r_ptr),
    .w_overflow_clr(w_overflow_clr), .w_ptr(w_ptr), .w_addr(w_addr),
    .w_mem_en(w_mem_en), .w_full(w_full), .w_almost_full(w_almost_full),
    .w_count(w_count), .w_overflow(w_overflow)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic          mem_en;
    logic [AS:0]   ptr;
    logic [AS-1:0] addr;
    logic          full;
    logic          af;
    logic [AS:0]   count;
    logic          ov;
  } exp_t;

  exp_t exp_q[$];
  event stim_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: total accepted writes, total reads, and the read totals seen by the two sync stages.
  int wr_total = 0, rd_total = 0, s1 = 0, s2 = 0;
  bit m_full = 0, m_ov = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  function automatic logic [AS:0] to_gray(input int n);
    int b;
    b = n % (2 * DEPTH);
    return (AS+1)'(b ^ (b >> 1));
  endfunction

  task automatic step(input bit inc, input bit clr, input bit rst, input bit rd_inc);
    exp_t e;
    int   fill;
    @(negedge w_clk);
    if (rst) rd_total = 0;
    else if (rd_inc && rd_total < wr_total) rd_total++;
    w_inc = inc; w_overflow_clr = clr; w_rst = rst; r_ptr = to_gray(rd_total);
    e.mem_en = inc && !m_full;
    if (rst) begin
      wr_total = 0; s1 = 0; s2 = 0; m_full = 0; m_ov = 0; fill = 0;
    end else begin
      if (inc && m_full) m_ov = 1;
      else if (clr) m_ov = 0;
      if (inc && !m_full) wr_total++;
      fill = wr_total - s2;
      s2 = s1;
      s1 = rd_total;
      m_full = (fill == DEPTH);
    end
    e.ptr   = to_gray(wr_total);
    e.addr  = AS'(wr_total % DEPTH);
    e.full  = m_full;
    e.af    = fill >= DEPTH - MARGIN;
    e.count = (AS+1)'(fill);
    e.ov    = m_ov;
    exp_q.push_back(e);
    -> stim_ev;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(stim_ev);
      #1;
      check("w_mem_en", {31'b0, w_mem_en}, {31'b0, exp_q[0].mem_en});
      @(posedge w_clk);
      #1;
      e = exp_q.pop_front();
      check("w_ptr", 32'(w_ptr), 32'(e.ptr));
      check("w_addr", 32'(w_addr), 32'(e.addr));
      check("w_full", {31'b0, w_full}, {31'b0, e.full});
      check("w_almost_full", {31'b0, w_almost_full}, {31'b0, e.af});
      check("w_count", 32'(w_count), 32'(e.count));
      check("w_overflow", {31'b0, w_overflow}, {31'b0, e.ov});
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    int rd_pct;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    // Fill to full with reads frozen, then keep requesting to provoke overflow.
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    // Release by one read; the write side sees it two edges later.
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Reset mid-fill.
    step(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // Reads trailing writes closely: many wraps with a small fill level.
    for (int i = 0; i < 80; i++) step(1, 0, 0, 1);
    // Random segments with varying read rates to visit empty, full and everything between.
    for (int seg = 0; seg < 12; seg++) begin
      rd_pct = (seg % 3 == 0) ? 20 : (seg % 3 == 1) ? 60 : 95;
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < 5,
             $urandom_range(0, 599) == 0,
             $urandom_range(0, 99) < rd_pct);
      end
    end
    step(0, 0, 0, 0);
    repeat (2) @(posedge w_clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d predictions never compared, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
